// File: rtl/word_serializer.sv
// ---------------------------------------------------------------------------
// word_serializer
//
// Purpose:
//   Parallel-to-serial converter with a valid/ready handshake on both sides.
//   A WIDTH-bit word is accepted on the load side while the block is idle.
//   It is then shifted out one bit per accepted serial transfer, either
//   MSB-first or LSB-first. A one-cycle done pulse marks the end of every
//   word.
//
// Optional feature:
//   WORD_SERIALIZER_PARITY_EN - when defined, one extra bit follows the data
//   bits. It is the even parity (XOR reduction) of the loaded word and is
//   sent in state PAR. When undefined, no parity state or logic exists and a
//   word is exactly WIDTH bits.
//
// Parameters:
//   WIDTH      - parallel word width in bits (2..32), default 32
//   MSB_FIRST  - 1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//
// Ports:
//   clk         in   single clock, all state updates on its rising edge
//   R           in   asynchronous active-low reset
//   in          in   parallel word offered for loading
//   load_valid  in   'in' holds a word offered for loading
//   load_ready  out  block can accept a word this cycle (IDLE only)
//   sout        out  current serial bit
//   sout_valid  out  sout carries a valid bit
//   sout_ready  in   downstream accepts the current bit
//   frame       out  high while sout carries the first data bit of a word
//   done        out  one-cycle pulse in the first IDLE cycle after the last
//                    bit of a word (data or parity) is accepted
// ---------------------------------------------------------------------------
module word_serializer #(
   parameter int WIDTH     = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             R,
   input  logic [WIDTH-1:0] in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   input  logic             sout_ready,
   output logic             frame,
   output logic             done
);

   // The counter can hold WIDTH itself, so it never wraps inside a word.
   localparam int                 CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef WORD_SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_e;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
   } state_e;
`endif

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   // Set on the first edge after reset release. It holds load_ready low
   // while R is low and through the release cycle, so the first accepted
   // load is on a clean edge.
   logic               run_q;
`ifdef WORD_SERIALIZER_PARITY_EN
   logic               parity_q, parity_d;
`endif

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge.
   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         state_q <= IDLE;
         // NOTE: the shift register is a datapath register, not a memory, so
         // it can be reset. Resetting it keeps sout deterministic after reset.
         sr_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         run_q   <= 1'b1;
      end
   end

`ifdef WORD_SERIALIZER_PARITY_EN
   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first. Then no path
      // leaves a value unassigned, and no latch is inferred.
      state_d    = state_q;
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      load_ready = 1'b0;
      sout       = 1'b0;
      sout_valid = 1'b0;
      frame      = 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
      parity_d   = parity_q;
`endif

      case (state_q)
         IDLE: begin
            load_ready = run_q;
            if (load_valid && run_q) begin
               // 'in' is sampled only here. Later changes to it cannot
               // reach the word in flight.
               sr_d    = in;
               cnt_d   = '0;
               state_d = SHIFT;
`ifdef WORD_SERIALIZER_PARITY_EN
               parity_d = ^in;
`endif
            end
         end

         SHIFT: begin
            sout_valid = 1'b1;
            sout       = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
            frame      = (cnt_q == '0);
            // With sout_ready low, nothing moves: sout, frame and the
            // counter hold for as long as the stall lasts.
            if (sout_ready) begin
               sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0}
                                : {1'b0, sr_q[WIDTH-1:1]};
               if (cnt_q == LAST_CNT) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                  state_d = PAR;
`else
                  state_d = IDLE;
                  done_d  = 1'b1;
`endif
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

`ifdef WORD_SERIALIZER_PARITY_EN
         PAR: begin
            sout_valid = 1'b1;
            sout       = parity_q;
            if (sout_ready) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // done is registered, so it is high exactly in the first IDLE cycle
   // after the final accepted bit, and a reset clears it at once.
   assign done = done_q;

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port R, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in, input, WIDTH bits: parallel word to transmit.
REQ-006 The block SHALL have port load_valid, input, 1 bit: in holds a word offered for loading.
REQ-007 The block SHALL have port load_ready, output, 1 bit: block can accept a word this cycle.
REQ-008 The block SHALL have port sout, output, 1 bit: current serial bit.
REQ-009 The block SHALL have port sout_valid, output, 1 bit: sout carries a valid bit.
REQ-010 The block SHALL have port sout_ready, input, 1 bit: downstream accepts the current bit.
REQ-011 The block SHALL have port frame, output, 1 bit: high while sout carries the first data bit of a word.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final bit of a word is accepted.

Function
REQ-013 The block SHALL implement states IDLE, SHIFT and PAR; PAR exists only when SER_PARITY_EN is defined.
REQ-014 The block SHALL drive load_ready high in IDLE only.
REQ-015 A load SHALL occur on a clock edge where load_valid and load_ready are both high: in is captured into a WIDTH-bit shift register, the bit counter is cleared, and the state goes to SHIFT.
REQ-016 In SHIFT, the block SHALL drive sout_valid high and sout from the shift register's output end, as selected by MSB_FIRST.
REQ-017 The first bit SHALL appear in the cycle after the load edge (latency 1).
REQ-018 A bit SHALL advance only on an edge with sout_valid and sout_ready both high; with sout_ready low, sout, frame and the counter SHALL hold unchanged for any number of cycles.
REQ-019 The block SHALL assert frame only while the counter is 0 in SHIFT.
REQ-020 After the WIDTH-th bit is accepted, the block SHALL go to PAR if SER_PARITY_EN is defined, and otherwise to IDLE.
REQ-021 The block SHALL pulse done high for exactly one cycle, in the first IDLE cycle after the final bit (data or parity) is accepted.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within a word.
REQ-023 load_valid with load_ready low SHALL be ignored; in SHALL be sampled only on the load edge, and later changes to in SHALL NOT affect the word in flight.
REQ-024 Back-to-back words SHALL be separated by at least one IDLE cycle; the sout_valid gap is exactly one cycle when load_valid is held high.

Reset
REQ-025 While R is low, the block SHALL force state IDLE, shift register and counter 0, load_ready 0, sout 0, sout_valid 0, frame 0 and done 0, independent of clk.
REQ-026 On the first clk edge after R rises, the block SHALL be in IDLE with load_ready high.
REQ-027 If R is asserted mid-word, the word in flight SHALL be discarded with no done pulse.

Configuration
REQ-028 The block SHALL support the macro WORD_SERIALIZER_PARITY_EN; the name SER_PARITY_EN elsewhere in this document denotes this macro.
REQ-029 With WORD_SERIALIZER_PARITY_EN defined, the block SHALL emit one extra bit in state PAR after the data bits, equal to the even parity (XOR) of the loaded word, with frame low and the same sout_ready stall rules.
REQ-030 Without WORD_SERIALIZER_PARITY_EN, no PAR state or parity logic SHALL exist, and a word SHALL occupy exactly WIDTH accepted bits.

Verification
REQ-031 The bench SHALL cover: WIDTH=32, MSB_FIRST=1, sout_ready=1, load 32'hA5000001 -> sout sequence 1,0,1,0,0,1,0,1, then 23 zeros, then 1; frame high on the first bit only; done pulses 1 cycle after the 32nd bit.
REQ-032 The bench SHALL cover: MSB_FIRST=0, load 32'h00000003 -> first two bits 1,1, then 30 zeros.
REQ-033 The bench SHALL cover: sout_ready low for 5 cycles at bit 10 -> sout, frame and counter held for those 5 cycles; total word time 37 cycles; no bit lost or duplicated.
REQ-034 The bench SHALL cover: WORD_SERIALIZER_PARITY_EN defined, load 32'h00000007 -> 32 data bits followed by parity bit 1; done only after the parity bit is accepted.
REQ-035 The bench SHALL cover: R pulsed low asynchronously at bit 15 -> all outputs 0 immediately, no done pulse; after release, load 32'hFFFFFFFF -> 32 ones.
REQ-036 The bench SHALL cover: load_valid held high with in changing every cycle -> a new word is captured only in IDLE cycles, in-flight data unaffected, one idle cycle between words.
